id_ex_latch: RTL and testbench

Decode-to-execute pipeline register for the 5-stage MIPS core. It captures decoded control, register-file read data and register specifiers at the end of ID and presents them to EX. It also feeds id_ex_rs, id_ex_rt, id_ex_wsel and id_ex_RegWr to the forwarding logic. The block detects load-use hazards itself, inserting the bubble and signalling upstream to hold, and keeps saturating bubble counters for performance debug.

---
 rtl/id_ex_latch.sv | 153 +++++++++++++++
 tb/tb_id_ex_latch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// Purpose: ID/EX pipeline register with load-use hazard detection and bubble counters.
// Latency: 1 cycle from id_* to id_ex_*; lu_stall is combinational from current state and ID inputs.
// Backpressure: freeze holds all state; lu_stall asks upstream to hold PC and IF/ID for one cycle.
// Ports: CLK/nRST (sync active-low reset), freeze/flush pipeline controls, id_* decoded
//        instruction fields in, id_ex_* registered copies out, lu_stall hazard hold out,
//        lu_bubbles/flush_bubbles saturating performance counters out.
module id_ex_latch #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_wsel,
  input  logic             id_uses_rt,
  input  logic             id_RegWr,
  input  logic             id_MemRd,
  input  logic             id_MemWr,
  input  logic             id_MemToReg,
  input  logic             id_ALUSrc,
  input  logic             id_halt,
  input  logic [3:0]       id_ALUOp,
  input  logic [31:0]      id_rdat1,
  input  logic [31:0]      id_rdat2,
  input  logic [31:0]      id_imm32,
  input  logic [31:0]      id_npc,
  output logic             id_ex_valid,
  output logic [4:0]       id_ex_rs,
  output logic [4:0]       id_ex_rt,
  output logic [4:0]       id_ex_wsel,
  output logic             id_ex_uses_rt,
  output logic             id_ex_RegWr,
  output logic             id_ex_MemRd,
  output logic             id_ex_MemWr,
  output logic             id_ex_MemToReg,
  output logic             id_ex_ALUSrc,
  output logic             id_ex_halt,
  output logic [3:0]       id_ex_ALUOp,
  output logic [31:0]      id_ex_rdat1,
  output logic [31:0]      id_ex_rdat2,
  output logic [31:0]      id_ex_imm32,
  output logic [31:0]      id_ex_npc,
  output logic             lu_stall,
  output logic [CNT_W-1:0] lu_bubbles,
  output logic [CNT_W-1:0] flush_bubbles
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        uses_rt;
    logic        RegWr;
    logic        MemRd;
    logic        MemWr;
    logic        MemToReg;
    logic        ALUSrc;
    logic        halt;
    logic [3:0]  ALUOp;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm32;
    logic [31:0] npc;
  } idex_t;

  idex_t            id_s;
  idex_t            stage_q, stage_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic             hz;

  always_comb begin
    id_s.valid    = id_valid;
    id_s.rs       = id_rs;
    id_s.rt       = id_rt;
    id_s.wsel     = id_wsel;
    id_s.uses_rt  = id_uses_rt;
    id_s.RegWr    = id_RegWr;
    id_s.MemRd    = id_MemRd;
    id_s.MemWr    = id_MemWr;
    id_s.MemToReg = id_MemToReg;
    id_s.ALUSrc   = id_ALUSrc;
    id_s.halt     = id_halt;
    id_s.ALUOp    = id_ALUOp;
    id_s.rdat1    = id_rdat1;
    id_s.rdat2    = id_rdat2;
    id_s.imm32    = id_imm32;
    id_s.npc      = id_npc;
  end

  // A load writing $0 never creates a hazard; that is the only place $0 is filtered.
  assign hz = stage_q.valid & stage_q.MemRd & (stage_q.wsel != 5'd0) & id_valid &
              ((stage_q.wsel == id_rs) | (id_uses_rt & (stage_q.wsel == id_rt)));

  // Flush already kills the dependent instruction, so no hold is needed.
  assign lu_stall = hz & ~flush;

  always_comb begin
    stage_d  = stage_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (!freeze) begin
      if (flush) begin
        stage_d = '0;
        if (fl_cnt_q != '1) fl_cnt_d = fl_cnt_q + CNT_W'(1);
      end else if (hz) begin
        stage_d = '0;
        if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end else if (id_valid) begin
        stage_d = id_s;
      end else begin
        // Invalid ID slot still loads an all-zero bubble so stale fields never reach EX.
        stage_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stage_q  <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      stage_q  <= stage_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign id_ex_valid    = stage_q.valid;
  assign id_ex_rs       = stage_q.rs;
  assign id_ex_rt       = stage_q.rt;
  assign id_ex_wsel     = stage_q.wsel;
  assign id_ex_uses_rt  = stage_q.uses_rt;
  assign id_ex_RegWr    = stage_q.RegWr;
  assign id_ex_MemRd    = stage_q.MemRd;
  assign id_ex_MemWr    = stage_q.MemWr;
  assign id_ex_MemToReg = stage_q.MemToReg;
  assign id_ex_ALUSrc   = stage_q.ALUSrc;
  assign id_ex_halt     = stage_q.halt;
  assign id_ex_ALUOp    = stage_q.ALUOp;
  assign id_ex_rdat1    = stage_q.rdat1;
  assign id_ex_rdat2    = stage_q.rdat2;
  assign id_ex_imm32    = stage_q.imm32;
  assign id_ex_npc      = stage_q.npc;
  assign lu_bubbles     = lu_cnt_q;
  assign flush_bubbles  = fl_cnt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Purpose: directed checks of the ID/EX latch: pass-through, load-use, freeze, flush, saturation, reset.
// Latency: expects id_ex_* one edge after inputs; lu_stall checked combinationally.
// Backpressure: freeze/flush/lu_stall exercised directly from the stimulus sequence.
module tb_id_ex_latch;

  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          nRST, freeze, flush;
  logic          id_valid, id_uses_rt, id_RegWr, id_MemRd, id_MemWr, id_MemToReg, id_ALUSrc, id_halt;
  logic [4:0]    id_rs, id_rt, id_wsel;
  logic [3:0]    id_ALUOp;
  logic [31:0]   id_rdat1, id_rdat2, id_imm32, id_npc;
  logic          id_ex_valid, id_ex_uses_rt, id_ex_RegWr, id_ex_MemRd, id_ex_MemWr;
  logic          id_ex_MemToReg, id_ex_ALUSrc, id_ex_halt;
  logic [4:0]    id_ex_rs, id_ex_rt, id_ex_wsel;
  logic [3:0]    id_ex_ALUOp;
  logic [31:0]   id_ex_rdat1, id_ex_rdat2, id_ex_imm32, id_ex_npc;
  logic          lu_stall;
  logic [CW-1:0] lu_bubbles, flush_bubbles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  id_ex_latch #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_uses_rt(id_uses_rt), .id_RegWr(id_RegWr), .id_MemRd(id_MemRd), .id_MemWr(id_MemWr),
    .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc), .id_halt(id_halt), .id_ALUOp(id_ALUOp),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm32(id_imm32), .id_npc(id_npc),
    .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_wsel(id_ex_wsel),
    .id_ex_uses_rt(id_ex_uses_rt), .id_ex_RegWr(id_ex_RegWr), .id_ex_MemRd(id_ex_MemRd),
    .id_ex_MemWr(id_ex_MemWr), .id_ex_MemToReg(id_ex_MemToReg), .id_ex_ALUSrc(id_ex_ALUSrc),
    .id_ex_halt(id_ex_halt), .id_ex_ALUOp(id_ex_ALUOp), .id_ex_rdat1(id_ex_rdat1),
    .id_ex_rdat2(id_ex_rdat2), .id_ex_imm32(id_ex_imm32), .id_ex_npc(id_ex_npc),
    .lu_stall(lu_stall), .lu_bubbles(lu_bubbles), .flush_bubbles(flush_bubbles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction; secondary fields derived from rdat1.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ws, input logic urt, input logic rw,
                       input logic mr, input logic [31:0] r1);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_wsel     = ws;
    id_uses_rt  = urt;
    id_RegWr    = rw;
    id_MemRd    = mr;
    id_MemWr    = 1'b0;
    id_MemToReg = mr;
    id_ALUSrc   = mr;
    id_halt     = 1'b0;
    id_ALUOp    = 4'd2;
    id_rdat1    = r1;
    id_rdat2    = r1 ^ 32'h0000_FFFF;
    id_imm32    = r1 + 32'd4;
    id_npc      = r1 + 32'd8;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; freeze = 1'b0; flush = 1'b0;
    drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, $urandom);
    id_halt = 1'b1;
    step(); step();
    chk("rst_valid",  id_ex_valid, 0);
    chk("rst_wsel",   id_ex_wsel, 0);
    chk("rst_rdat1",  id_ex_rdat1, 0);
    chk("rst_halt",   id_ex_halt, 0);
    chk("rst_memrd",  id_ex_MemRd, 0);
    chk("rst_lucnt",  lu_bubbles, 0);
    chk("rst_flcnt",  flush_bubbles, 0);
    chk("rst_stall",  lu_stall, 0);

    // add $3,$1,$2
    nRST = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h11);
    step();
    chk("pass_rs",    id_ex_rs, 1);
    chk("pass_wsel",  id_ex_wsel, 3);
    chk("pass_rdat1", id_ex_rdat1, 32'h11);
    chk("pass_rdat2", id_ex_rdat2, 32'h0000_FFEE);
    chk("pass_imm",   id_ex_imm32, 32'h15);
    chk("pass_npc",   id_ex_npc, 32'h19);
    chk("pass_valid", id_ex_valid, 1);
    chk("pass_regwr", id_ex_RegWr, 1);
    chk("pass_aluop", id_ex_ALUOp, 2);

    // lw $5 then add using rs=$5
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 32'h100);
    step();
    chk("lw_memrd",   id_ex_MemRd, 1);
    drive(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 32'h22);
    #1;
    chk("lu_rs_stall", lu_stall, 1);
    step();
    chk("lu_bub_valid", id_ex_valid, 0);
    chk("lu_bub_wsel",  id_ex_wsel, 0);
    chk("lu_bub_regwr", id_ex_RegWr, 0);
    chk("lu_bub_rdat1", id_ex_rdat1, 0);
    chk("lu_cnt1",      lu_bubbles, 1);
    chk("lu_after_stall", lu_stall, 0);
    step();
    chk("lu_dep_rs",    id_ex_rs, 5);
    chk("lu_dep_wsel",  id_ex_wsel, 6);
    chk("lu_dep_valid", id_ex_valid, 1);
    chk("lu_cnt_hold",  lu_bubbles, 1);

    // lw $5 then rt=$5 with uses_rt=0: no stall
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 32'h104);
    step();
    drive(1'b1, 5'd4, 5'd5, 5'd7, 1'b0, 1'b1, 1'b0, 32'h33);
    #1;
    chk("nort_stall", lu_stall, 0);
    step();
    chk("nort_wsel",  id_ex_wsel, 7);
    chk("nort_cnt",   lu_bubbles, 1);

    // lw $5 then rt=$5 with uses_rt=1: stall
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 32'h108);
    step();
    drive(1'b1, 5'd4, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 32'h44);
    #1;
    chk("rt_stall", lu_stall, 1);
    step();
    chk("rt_bub_valid", id_ex_valid, 0);
    chk("rt_cnt2",      lu_bubbles, 2);

    // lw $0 then user of $0: no hazard
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h10C);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h55);
    #1;
    chk("z0_stall", lu_stall, 0);
    step();
    chk("z0_wsel",  id_ex_wsel, 8);
    chk("z0_valid", id_ex_valid, 1);
    chk("z0_cnt",   lu_bubbles, 2);

    // freeze 3 edges with changing inputs; flush raised on the second
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 5'(11 + i), 5'(12 + i), 1'b1, 1'b1, 1'b0, 32'h1000 + i);
      if (i == 1) flush = 1'b1;
      step();
      chk("frz_wsel",  id_ex_wsel, 8);
      chk("frz_rdat1", id_ex_rdat1, 32'h55);
      chk("frz_flcnt", flush_bubbles, 0);
    end
    freeze = 1'b0;
    step();
    chk("frz_flush_valid", id_ex_valid, 0);
    chk("frz_flush_wsel",  id_ex_wsel, 0);
    chk("frz_flush_cnt",   flush_bubbles, 1);
    flush = 1'b0;

    // flush together with hz: single bubble counted as flush
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 32'h110);
    step();
    drive(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 32'h66);
    flush = 1'b1;
    #1;
    chk("flhz_stall", lu_stall, 0);
    step();
    chk("flhz_valid", id_ex_valid, 0);
    chk("flhz_flcnt", flush_bubbles, 2);
    chk("flhz_lucnt", lu_bubbles, 2);

    // five consecutive flushes: saturate at 3
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_flcnt", flush_bubbles, 3);
    end
    flush = 1'b0;

    // invalid ID slot loads a bubble
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 32'h77);
    step();
    chk("iv_pre_valid", id_ex_valid, 1);
    drive(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 32'h88);
    id_halt = 1'b1;
    step();
    chk("iv_valid", id_ex_valid, 0);
    chk("iv_rdat1", id_ex_rdat1, 0);
    chk("iv_halt",  id_ex_halt, 0);

    // halt passes as a normal field
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 32'h99);
    id_halt = 1'b1;
    step();
    chk("halt_pass", id_ex_halt, 1);

    // reset under freeze clears everything
    freeze = 1'b1;
    nRST   = 1'b0;
    step();
    chk("mrst_valid", id_ex_valid, 0);
    chk("mrst_rdat1", id_ex_rdat1, 0);
    chk("mrst_halt",  id_ex_halt, 0);
    chk("mrst_flcnt", flush_bubbles, 0);
    chk("mrst_lucnt", lu_bubbles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
